// File: rtl/eth_tx_arb_pkg.sv
// eth_tx_arb_pkg: shared state type, tuser bit map and round-robin helper for the TX frame arbiter
package eth_tx_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, DROP} state_t;
  localparam int TUSER_BAD_BIT = 0;
  localparam int MAX_PORTS = 8;
  function automatic logic [2:0] rr_next(input logic [MAX_PORTS-1:0] req, input logic [2:0] last, input int ports = MAX_PORTS);
    logic [2:0] idx;
    logic found;
    rr_next = last;
    found = 1'b0;
    for (int i = 1; i <= MAX_PORTS; i++) begin
      idx = 3'((int'(last) + i) % ports);
      if (i <= ports && !found && req[idx]) begin
        rr_next = idx;
        found = 1'b1;
      end
    end
  endfunction
endpackage

// File: rtl/eth_tx_frame_arbiter_if.sv
// eth_tx_frame_arbiter_if: per-source AXI-Stream inputs and the single MAC-side AXI-Stream output
interface eth_tx_frame_arbiter_if #(
  parameter int PORTS = 2,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata;
  logic [PORTS-1:0] s_axis_tvalid;
  logic [PORTS-1:0] s_axis_tready;
  logic [PORTS-1:0] s_axis_tlast;
  logic [PORTS*USER_WIDTH-1:0] s_axis_tuser;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic m_axis_tvalid;
  logic m_axis_tready;
  logic m_axis_tlast;
  logic [USER_WIDTH-1:0] m_axis_tuser;
  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
    input s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
  );
  modport slave (
    input s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
  );
endinterface

// File: rtl/rr_priority_select.sv
// rr_priority_select: picks the first requester strictly after last, wrapping modulo PORTS
module rr_priority_select import eth_tx_arb_pkg::*; #(
  parameter int PORTS = 2,
  localparam int IW = $clog2(PORTS)
) (
  input  logic [PORTS-1:0] req,
  input  logic [IW-1:0] last,
  output logic valid,
  output logic [IW-1:0] index
);
  always_comb begin
    valid = |req;
    index = IW'(rr_next(MAX_PORTS'(req), 3'(last), PORTS));
  end
endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// eth_tx_frame_arbiter: frame-level round-robin arbiter sharing one 8-bit GMII TX MAC stream
module eth_tx_frame_arbiter import eth_tx_arb_pkg::*; #(
  parameter int PORTS = 2,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int MAX_FRAME_LEN = 1514,
  localparam int IW = $clog2(PORTS)
) (
  input  logic clk,
  input  logic rst,
  eth_tx_frame_arbiter_if.slave axis,
  input  logic [PORTS-1:0] port_enable,
  input  logic tx_pause,
  output logic grant_valid,
  output logic [IW-1:0] grant_index,
  output logic frame_done,
  output logic frame_truncated
);
  localparam int CW = MAX_FRAME_LEN > 0 ? $clog2(MAX_FRAME_LEN + 1) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_FRAME_LEN > 0 ? MAX_FRAME_LEN - 1 : 0);
  if (DATA_WIDTH != 8) begin : g_width_check
    $error("eth_tx_frame_arbiter: DATA_WIDTH must be 8");
  end
  if (PORTS < 2 || PORTS > MAX_PORTS) begin : g_ports_check
    $error("eth_tx_frame_arbiter: PORTS must be 2..8");
  end
  state_t state, state_n;
  logic [IW-1:0] last_grant, sel_index;
  logic [CW-1:0] beat_cnt;
  logic sel_valid, g_valid, g_last, hs, trunc, active;
  logic [DATA_WIDTH-1:0] g_data;
  logic [USER_WIDTH-1:0] g_user;
  rr_priority_select #(.PORTS(PORTS)) u_select (
    .req(axis.s_axis_tvalid & port_enable),
    .last(last_grant),
    .valid(sel_valid),
    .index(sel_index)
  );
  always_comb begin
    g_data = '0;
    g_user = '0;
    g_valid = 1'b0;
    g_last = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (grant_index == IW'(i)) begin
        g_data = axis.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        g_user = axis.s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
        g_valid = axis.s_axis_tvalid[i];
        g_last = axis.s_axis_tlast[i];
      end
    end
  end
  // the cut beat is forced to tlast with the bad-frame flag so the MAC raises tx_er
  always_comb begin
    active = state == ACTIVE;
    hs = active && g_valid && axis.m_axis_tready;
    trunc = MAX_FRAME_LEN > 0 && beat_cnt == LAST_CNT && !g_last;
    axis.m_axis_tvalid = active && g_valid;
    axis.m_axis_tdata = active ? g_data : '0;
    axis.m_axis_tlast = active && (g_last || trunc);
    axis.m_axis_tuser = active ? g_user | (USER_WIDTH'(trunc) << TUSER_BAD_BIT) : '0;
    axis.s_axis_tready = '0;
    axis.s_axis_tready[grant_index] = active ? axis.m_axis_tready : state == DROP;
    state_n = state == IDLE ? (!tx_pause && sel_valid ? ACTIVE : IDLE) :
              state == ACTIVE ? (hs && g_last ? IDLE : hs && trunc ? DROP : ACTIVE) :
              (g_valid && g_last ? IDLE : DROP);
  end
  assign grant_valid = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last_grant <= IW'(PORTS - 1);
      grant_index <= '0;
      beat_cnt <= '0;
      frame_done <= 1'b0;
      frame_truncated <= 1'b0;
    end else begin
      state <= state_n;
      frame_done <= hs && (g_last || trunc);
      frame_truncated <= hs && trunc;
      if (state == IDLE && state_n == ACTIVE) begin
        grant_index <= sel_index;
        last_grant <= sel_index;
        beat_cnt <= '0;
      end else if (hs && beat_cnt != '1) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// tb_eth_tx_frame_arbiter: random per-port frame sources checked against a frame-level arbitration model
module tb_eth_tx_frame_arbiter;
  localparam int NP = 2;
  localparam int MAXL = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NP-1:0] port_enable = '0;
  logic tx_pause = 1'b0;
  logic grant_valid, frame_done, frame_truncated;
  logic [0:0] grant_index;
  int n_chk = 0;
  int n_err = 0;
  eth_tx_frame_arbiter_if #(.PORTS(NP), .DATA_WIDTH(8), .USER_WIDTH(1)) ifc ();
  eth_tx_frame_arbiter #(.PORTS(NP), .DATA_WIDTH(8), .USER_WIDTH(1), .MAX_FRAME_LEN(MAXL)) dut (
    .clk(clk),
    .rst(rst),
    .axis(ifc),
    .port_enable(port_enable),
    .tx_pause(tx_pause),
    .grant_valid(grant_valid),
    .grant_index(grant_index),
    .frame_done(frame_done),
    .frame_truncated(frame_truncated)
  );
  always #5 clk = ~clk;
  // sources
  logic [7:0] src_data[NP][20];
  int src_len[NP];
  int src_pos[NP];
  logic [NP-1:0] src_act = '0;
  logic [NP-1:0] src_user = '0;
  logic [NP-1:0] vld = '0;
  logic [NP-1:0] acc = '0;
  bit gen = 1'b0;
  int rdy_pct, vld_pct, pause_pct, en_mode;
  // reference: expected MAC beats per port as {is_cut, tuser, tlast, tdata}
  logic [10:0] exp_q[NP][$];
  bit busy = 1'b0, dropping = 1'b0, exp_done = 1'b0, exp_trunc = 1'b0;
  int ref_port = 0;
  int ref_last = NP - 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr(input logic [NP-1:0] req, input int last);
    for (int k = 1; k <= NP; k++) if (req[(last + k) % NP]) return (last + k) % NP;
    return -1;
  endfunction

  task automatic new_frame(input int p);
    int len, n_out;
    bit cut;
    len = $urandom_range(1, 20);
    if ($urandom_range(0, 4) == 0) len = MAXL - 1 + $urandom_range(0, 2);
    src_len[p] = len;
    src_pos[p] = 0;
    src_act[p] = 1'b1;
    src_user[p] = 1'($urandom_range(0, 1));
    for (int i = 0; i < len; i++) src_data[p][i] = 8'($urandom);
    n_out = len > MAXL ? MAXL : len;
    for (int i = 0; i < n_out; i++) begin
      cut = len > MAXL && i == MAXL - 1;
      exp_q[p].push_back({cut, cut ? 1'b1 : src_user[p], i == n_out - 1, src_data[p][i]});
    end
  endtask

  task automatic apply();
    for (int p = 0; p < NP; p++) begin
      ifc.s_axis_tdata[p*8 +: 8] = src_act[p] ? src_data[p][src_pos[p]] : 8'h00;
      ifc.s_axis_tlast[p] = src_act[p] && src_pos[p] == src_len[p] - 1;
      ifc.s_axis_tuser[p] = src_act[p] && src_user[p];
    end
    ifc.s_axis_tvalid = vld;
  endtask

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      if (acc[p]) begin
        vld[p] = 1'b0;
        if (src_pos[p] == src_len[p] - 1) src_act[p] = 1'b0;
        else src_pos[p]++;
      end
      if (!src_act[p] && gen) new_frame(p);
      if (src_act[p] && !vld[p]) vld[p] = $urandom_range(0, 99) < vld_pct;
    end
    acc = '0;
    ifc.m_axis_tready = $urandom_range(0, 99) < rdy_pct;
    if ($urandom_range(0, 7) == 0) tx_pause = $urandom_range(0, 99) < pause_pct;
    if (en_mode != 1 || $urandom_range(0, 7) == 0)
      port_enable = en_mode == 0 ? 2'b11 : en_mode == 2 ? 2'b01 : 2'($urandom_range(0, 3));
    apply();
  endtask

  task automatic model_check();
    logic [NP-1:0] er, req;
    logic [10:0] e;
    bit was_busy, mv;
    chk("frame_done", 32'(frame_done), 32'(exp_done));
    chk("frame_truncated", 32'(frame_truncated), 32'(exp_trunc));
    exp_done = 1'b0;
    exp_trunc = 1'b0;
    chk("grant_valid", 32'(grant_valid), 32'(busy));
    if (busy) chk("grant_index", 32'(grant_index), 32'(ref_port));
    er = '0;
    if (busy) er[ref_port] = dropping ? 1'b1 : ifc.m_axis_tready;
    chk("s_axis_tready", 32'(ifc.s_axis_tready), 32'(er));
    mv = busy && !dropping && vld[ref_port];
    chk("m_axis_tvalid", 32'(ifc.m_axis_tvalid), 32'(mv));
    acc = vld & er;
    was_busy = busy;
    if (!busy) begin
      chk("idle_out", 32'({ifc.m_axis_tuser, ifc.m_axis_tlast, ifc.m_axis_tdata}), 32'(0));
    end else if (!dropping) begin
      if (mv && ifc.m_axis_tready) begin
        chk("exp_q_nonempty", 32'(exp_q[ref_port].size() != 0), 32'(1));
        if (exp_q[ref_port].size() != 0) begin
          e = exp_q[ref_port].pop_front();
          chk("beat", 32'({ifc.m_axis_tuser, ifc.m_axis_tlast, ifc.m_axis_tdata}), 32'(e[9:0]));
          if (e[8]) begin
            exp_done = 1'b1;
            exp_trunc = e[10];
            dropping = e[10];
            busy = e[10];
          end
        end
      end
    end else if (vld[ref_port] && src_pos[ref_port] == src_len[ref_port] - 1) begin
      busy = 1'b0;
      dropping = 1'b0;
    end
    if (!was_busy) begin
      req = vld & port_enable;
      if (!tx_pause && req != 0) begin
        ref_port = rr(req, ref_last);
        ref_last = ref_port;
        busy = 1'b1;
        dropping = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    model_check();
  endtask

  task automatic knobs(input int r, input int v, input int pz, input int en);
    rdy_pct = r;
    vld_pct = v;
    pause_pct = pz;
    en_mode = en;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    int left = 0;
    gen = 1'b0;
    knobs(100, 100, 0, 0);
    tx_pause = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      step();
      ok = !busy && src_act == '0;
    end
    chk("drain_done", 32'(ok), 32'(1));
    step();
    for (int p = 0; p < NP; p++) left += exp_q[p].size();
    chk("exp_q_drained", 32'(left), 32'(0));
  endtask

  task automatic check_reset_outputs();
    chk("rst_grant_valid", 32'(grant_valid), 32'(0));
    chk("rst_grant_index", 32'(grant_index), 32'(0));
    chk("rst_s_tready", 32'(ifc.s_axis_tready), 32'(0));
    chk("rst_m_tvalid", 32'(ifc.m_axis_tvalid), 32'(0));
    chk("rst_m_tdata", 32'(ifc.m_axis_tdata), 32'(0));
    chk("rst_m_tlast_tuser", 32'({ifc.m_axis_tlast, ifc.m_axis_tuser}), 32'(0));
    chk("rst_pulses", 32'({frame_done, frame_truncated}), 32'(0));
  endtask

  initial begin
    bit hit;
    knobs(100, 100, 0, 0);
    ifc.m_axis_tready = 1'b0;
    apply();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    gen = 1'b1;
    knobs(100, 100, 0, 0);
    repeat (500) step();
    knobs(50, 80, 0, 0);
    repeat (800) step();
    knobs(70, 70, 30, 1);
    repeat (1000) step();
    knobs(90, 90, 0, 2);
    repeat (600) step();
    knobs(60, 60, 15, 1);
    repeat (1000) step();
    drain();
    // reset while beat 5 of a frame is on the bus
    gen = 1'b1;
    knobs(100, 100, 0, 0);
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      step();
      hit = busy && !dropping && src_act[ref_port] && src_pos[ref_port] == 4;
    end
    chk("mid_frame_reached", 32'(hit), 32'(1));
    rst = 1'b1;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    for (int p = 0; p < NP; p++) exp_q[p].delete();
    src_act = '0;
    vld = '0;
    acc = '0;
    busy = 1'b0;
    dropping = 1'b0;
    exp_done = 1'b0;
    exp_trunc = 1'b0;
    ref_last = NP - 1;
    tx_pause = 1'b0;
    ifc.m_axis_tready = 1'b0;
    apply();
    @(negedge clk);
    rst = 1'b0;
    step();
    step();
    chk("post_rst_grant_valid", 32'(grant_valid), 32'(1));
    chk("post_rst_grant_index", 32'(grant_index), 32'(0));
    repeat (300) step();
    drain();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
